seg7_bcd_counter_mux: RTL and testbench

//  Parametrised N-digit BCD up/down counter driving a time-multiplexed common-anode

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_bcd_counter_mux_if.sv | 24 ++
 rtl/seg7_bcd_digit.sv | 36 +++
 rtl/seg7_bcd_counter_mux.sv | 112 +++++++++++
 tb/tb_seg7_bcd_counter_mux.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - seven-segment constants and BCD-to-segment decode
package seg7_pkg;

  // Active-low segment order is {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100   // 9
  };

  // Codes above 9 are not digits and show nothing
  function automatic logic [6:0] bcd_to_seg7(input logic [3:0] bcd);
    logic [6:0] seg;
    seg = SEG_BLANK;
    if (bcd <= 4'd9) seg = SEG_DIGIT[bcd];
    return seg;
  endfunction

endpackage

// File: rtl/seg7_bcd_counter_mux_if.sv
// rtl/seg7_bcd_counter_mux_if.sv - control and display signal bundle for the BCD counter
interface seg7_bcd_counter_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    up_dn;
  logic                    clear;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic [4*NUM_DIGITS-1:0] count_bcd;
  logic                    wrap;
  logic [NUM_DIGITS-1:0]   anode;
  logic [6:0]              cathode;

  modport master (
    output en, up_dn, clear, load, load_val,
    input  count_bcd, wrap, anode, cathode
  );

  modport slave (
    input  en, up_dn, clear, load, load_val,
    output count_bcd, wrap, anode, cathode
  );
endinterface

// File: rtl/seg7_bcd_digit.sv
// rtl/seg7_bcd_digit.sv - one BCD digit with up/down step, carry/borrow chain, load and clear
module seg7_bcd_digit (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       step,      // carry (up) or borrow (down) into this digit
  input  logic       up_dn,
  output logic [3:0] digit,
  output logic       step_out   // carry/borrow into the next digit
);

  logic at_limit;

  // A digit sitting at its rollover value passes the step upward
  always_comb begin
    at_limit = up_dn ? (digit == 4'd9) : (digit == 4'd0);
    step_out = step & at_limit;
  end

  // Digit register: clear beats load beats step; non-BCD load codes become 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= 4'd0;
    end else if (clear) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= (load_digit > 4'd9) ? 4'd0 : load_digit;
    end else if (step) begin
      if (at_limit) digit <= up_dn ? 4'd0 : 4'd9;
      else          digit <= up_dn ? digit + 4'd1 : digit - 4'd1;
    end
  end

endmodule

// File: rtl/seg7_bcd_counter_mux.sv
// rtl/seg7_bcd_counter_mux.sv - N-digit BCD up/down counter with multiplexed 7-seg scan (option: LEADING_ZERO_BLANK_EN)
module seg7_bcd_counter_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int COUNT_DIV  = 50_000_000,
  parameter int SCAN_DIV   = 100_000
) (
  input logic                  clk,
  input logic                  reset,
  seg7_bcd_counter_mux_if.slave bus
);

  localparam int CW = (COUNT_DIV  > 1) ? $clog2(COUNT_DIV)  : 1;
  localparam int SW = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]                count_pre;
  logic                         tick;
  logic [NUM_DIGITS:0]          step_chain;
  logic [NUM_DIGITS-1:0][3:0]   digits;
  logic                         wrap_q;
  logic [SW-1:0]                scan_pre;
  logic [IW-1:0]                scan_idx;
  logic [NUM_DIGITS-1:0]        blank;
  logic [NUM_DIGITS-1:0]        anode_q;
  logic [6:0]                   cathode_q;

  assign tick = bus.en & (count_pre == CW'(COUNT_DIV - 1));

  // Count prescaler: runs only while enabled, restarts on clear/load or after a tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_pre <= '0;
    end else if (bus.clear || bus.load || tick) begin
      count_pre <= '0;
    end else if (bus.en) begin
      count_pre <= count_pre + 1'b1;
    end
  end

  // Digit chain: the tick steps digit 0, carries/borrows ripple upward
  assign step_chain[0] = tick;

  genvar gi;
  for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    seg7_bcd_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .clear      (bus.clear),
      .load       (bus.load),
      .load_digit (bus.load_val[4*gi +: 4]),
      .step       (step_chain[gi]),
      .up_dn      (bus.up_dn),
      .digit      (digits[gi]),
      .step_out   (step_chain[gi+1])
    );
  end

  assign bus.count_bcd = digits;

  // Wrap pulse lands in the same cycle the rolled-over count appears
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wrap_q <= 1'b0;
    else       wrap_q <= tick & step_chain[NUM_DIGITS] & ~bus.clear & ~bus.load;
  end

  assign bus.wrap = wrap_q;

  // Scan prescaler and digit index: free-running, unaffected by count controls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_pre <= '0;
      scan_idx <= '0;
    end else if (scan_pre == SW'(SCAN_DIV - 1)) begin
      scan_pre <= '0;
      scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end else begin
      scan_pre <= scan_pre + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every digit above it are zero; digit 0 always shows
  always_comb begin
    logic above_zero;
    blank      = '0;
    above_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      above_zero = above_zero & (digits[k] == 4'd0);
      blank[k]   = above_zero;
    end
  end
`else
  assign blank = '0;
`endif

  // Anode and cathode registered together from the same scan index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode_q   <= '1;
      cathode_q <= SEG_BLANK;
    end else begin
      anode_q   <= ~(NUM_DIGITS'(1) << scan_idx);
      cathode_q <= blank[scan_idx] ? SEG_BLANK : bcd_to_seg7(digits[scan_idx]);
    end
  end

  assign bus.anode   = anode_q;
  assign bus.cathode = cathode_q;

endmodule

// File: tb/tb_seg7_bcd_counter_mux.sv
// tb/tb_seg7_bcd_counter_mux.sv - self-checking bench for seg7_bcd_counter_mux against an integer model
module tb_seg7_bcd_counter_mux;
  localparam int ND   = 3;
  localparam int CD   = 4;
  localparam int SD   = 3;
  localparam int MAXV = 1000;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  seg7_bcd_counter_mux_if #(.NUM_DIGITS(ND)) bus ();

  seg7_bcd_counter_mux #(.NUM_DIGITS(ND), .COUNT_DIV(CD), .SCAN_DIV(SD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Active-low {a..g} shapes of decimal digits
  logic [6:0] seg_tab [0:9] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

  // Reference model: count as a plain integer 0..999
  int m_val  = 0;
  int m_pre  = 0;
  int m_cyc  = 0;
  int m_disp = 0;
  bit m_wrap = 1'b0;

  function automatic int bcd_to_int(input logic [4*ND-1:0] v);
    int r = 0;
    for (int d = ND - 1; d >= 0; d--) begin
      int x;
      x = int'(v[4*d +: 4]);
      if (x > 9) x = 0;
      r = r * 10 + x;
    end
    return r;
  endfunction

  function automatic logic [4*ND-1:0] int_to_bcd(input int n);
    logic [4*ND-1:0] r;
    for (int d = 0; d < ND; d++) r[4*d +: 4] = 4'((n / (10 ** d)) % 10);
    return r;
  endfunction

  function automatic logic [ND-1:0] exp_anode();
    logic [ND-1:0] a;
    a = '1;
    if (m_cyc > 0) a[((m_cyc - 1) / SD) % ND] = 1'b0;
    return a;
  endfunction

  function automatic logic [6:0] exp_cathode();
    int idx;
    if (m_cyc == 0) return 7'h7F;
    idx = ((m_cyc - 1) / SD) % ND;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && m_disp < 10 ** idx) return 7'h7F;
`endif
    return seg_tab[(m_disp / (10 ** idx)) % 10];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_val <= 0; m_pre <= 0; m_cyc <= 0; m_disp <= 0; m_wrap <= 1'b0;
    end else begin
      m_cyc  <= m_cyc + 1;
      m_disp <= m_val;
      m_wrap <= 1'b0;
      if (bus.clear) begin
        m_val <= 0; m_pre <= 0;
      end else if (bus.load) begin
        m_val <= bcd_to_int(bus.load_val); m_pre <= 0;
      end else if (bus.en) begin
        if (m_pre == CD - 1) begin
          m_pre <= 0;
          if (bus.up_dn) begin
            m_val <= (m_val + 1) % MAXV;        m_wrap <= (m_val == MAXV - 1);
          end else begin
            m_val <= (m_val + MAXV - 1) % MAXV; m_wrap <= (m_val == 0);
          end
        end else begin
          m_pre <= m_pre + 1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.en = 1'b0; bus.up_dn = 1'b1; bus.clear = 1'b0; bus.load = 1'b0; bus.load_val = '0;
    #1;
    checks++;
    if (bus.count_bcd !== 12'h000 || bus.wrap !== 1'b0 || bus.anode !== 3'b111 || bus.cathode !== 7'h7F) begin
      failures++;
      $display("FAIL reset_initial count=%h wrap=%b anode=%b cathode=%b required 000 0 111 1111111", bus.count_bcd, bus.wrap, bus.anode, bus.cathode);
    end
    @(negedge clk); reset = 1'b0;
    bus.load = 1'b1; bus.load_val = 12'h123; bus.en = 1'b1;
    cyc(); bus.load = 1'b0;
    repeat (10) cyc();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.count_bcd !== 12'h000 || bus.wrap !== 1'b0 || bus.anode !== 3'b111 || bus.cathode !== 7'h7F) begin
      failures++;
      $display("FAIL reset_mid_count count=%h wrap=%b anode=%b cathode=%b required 000 0 111 1111111", bus.count_bcd, bus.wrap, bus.anode, bus.cathode);
    end
    bus.en = 1'b0;
    @(negedge clk); reset = 1'b0;
    cyc();
    checks++;
    if (bus.anode !== 3'b110 || bus.cathode !== 7'b0000001) begin
      failures++;
      $display("FAIL reset_first_scan anode=%b cathode=%b required 110 0000001", bus.anode, bus.cathode);
    end
  endtask

  task automatic test_wrap_up();
    bus.load = 1'b1; bus.load_val = 12'h998; bus.up_dn = 1'b1; bus.en = 1'b1;
    cyc(); bus.load = 1'b0;
    checks++;
    if (bus.count_bcd !== 12'h998 || bus.wrap !== 1'b0) begin
      failures++; $display("FAIL wrap_up_load count=%h wrap=%b required 998 0", bus.count_bcd, bus.wrap);
    end
    for (int k = 1; k <= 9; k++) begin
      cyc();
      checks++;
      if (bus.count_bcd !== int_to_bcd(m_val) || bus.wrap !== m_wrap) begin
        failures++;
        $display("FAIL wrap_up_model k=%0d count=%h wrap=%b required %h %b", k, bus.count_bcd, bus.wrap, int_to_bcd(m_val), m_wrap);
      end
      if (k == 4 || k == 8 || k == 9) begin
        logic [11:0] ec;
        logic        ew;
        ec = (k == 4) ? 12'h999 : 12'h000;
        ew = (k == 8);
        checks++;
        if (bus.count_bcd !== ec || bus.wrap !== ew) begin
          failures++; $display("FAIL wrap_up_k%0d count=%h wrap=%b required %h %b", k, bus.count_bcd, bus.wrap, ec, ew);
        end
      end
    end
  endtask

  task automatic test_wrap_down();
    bus.load = 1'b1; bus.load_val = 12'h000; bus.up_dn = 1'b0; bus.en = 1'b1;
    cyc(); bus.load = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      checks++;
      if (bus.count_bcd !== int_to_bcd(m_val) || bus.wrap !== m_wrap) begin
        failures++;
        $display("FAIL wrap_down_model k=%0d count=%h wrap=%b required %h %b", k, bus.count_bcd, bus.wrap, int_to_bcd(m_val), m_wrap);
      end
      if (k == 4 || k == 5 || k == 8) begin
        logic [11:0] ec;
        logic        ew;
        ec = (k == 8) ? 12'h998 : 12'h999;
        ew = (k == 4);
        checks++;
        if (bus.count_bcd !== ec || bus.wrap !== ew) begin
          failures++; $display("FAIL wrap_down_k%0d count=%h wrap=%b required %h %b", k, bus.count_bcd, bus.wrap, ec, ew);
        end
      end
    end
  endtask

  task automatic test_load_tick();
    int guard = 0;
    bus.up_dn = 1'b1; bus.en = 1'b1;
    while (m_pre != CD - 1 && guard < 10) begin
      cyc(); guard++;
    end
    checks++;
    if (m_pre != CD - 1) begin
      failures++; $display("FAIL load_tick_align prescale=%0d required %0d", m_pre, CD - 1);
    end
    bus.load = 1'b1; bus.load_val = 12'h5A7;
    cyc(); bus.load = 1'b0;
    checks++;
    if (bus.count_bcd !== 12'h507 || bus.wrap !== 1'b0) begin
      failures++; $display("FAIL load_tick_value count=%h wrap=%b required 507 0", bus.count_bcd, bus.wrap);
    end
    for (int k = 1; k <= 4; k++) begin
      logic [11:0] ec;
      cyc();
      ec = (k == 4) ? 12'h508 : 12'h507;
      checks++;
      if (bus.count_bcd !== ec) begin
        failures++; $display("FAIL load_tick_next k=%0d count=%h required %h", k, bus.count_bcd, ec);
      end
    end
  endtask

  task automatic test_scan();
    logic [2:0] prev_anode;
    int         run;
    bit         first_run;
    logic [6:0] hi;
`ifdef LEADING_ZERO_BLANK_EN
    hi = 7'h7F;
`else
    hi = 7'b0000001;
`endif
    bus.load = 1'b1; bus.load_val = 12'h042; bus.en = 1'b0;
    cyc(); bus.load = 1'b0;
    cyc();
    prev_anode = bus.anode; run = 1; first_run = 1'b1;
    for (int k = 0; k < 18; k++) begin
      logic [6:0] ecat;
      cyc();
      checks++;
      if (bus.anode !== exp_anode() || bus.cathode !== exp_cathode()) begin
        failures++;
        $display("FAIL scan_model k=%0d anode=%b cathode=%b required %b %b", k, bus.anode, bus.cathode, exp_anode(), exp_cathode());
      end
      case (bus.anode)
        3'b110:  ecat = 7'b0010010;
        3'b101:  ecat = 7'b1001100;
        3'b011:  ecat = hi;
        default: ecat = 7'bxxxxxxx;
      endcase
      checks++;
      if (bus.cathode !== ecat) begin
        failures++; $display("FAIL scan_pattern anode=%b cathode=%b required %b", bus.anode, bus.cathode, ecat);
      end
      if (bus.anode === prev_anode) begin
        run++;
      end else begin
        if (!first_run) begin
          checks++;
          if (run != SD) begin
            failures++; $display("FAIL scan_slot_len anode=%b cycles=%0d required %0d", prev_anode, run, SD);
          end
        end
        first_run = 1'b0; run = 1; prev_anode = bus.anode;
      end
    end
  endtask

  task automatic test_enable_hold();
    int changes = 0;
    logic [2:0] pa;
    bus.load = 1'b1; bus.load_val = 12'h300; bus.up_dn = 1'b1; bus.en = 1'b1;
    cyc(); bus.load = 1'b0;
    cyc();
    bus.en = 1'b0;
    pa = bus.anode;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (bus.anode !== pa) changes++;
      pa = bus.anode;
      checks++;
      if (bus.count_bcd !== 12'h300 || bus.wrap !== 1'b0) begin
        failures++; $display("FAIL en_hold k=%0d count=%h wrap=%b required 300 0", k, bus.count_bcd, bus.wrap);
      end
    end
    checks++;
    if (changes < 5) begin
      failures++; $display("FAIL en_hold_scan anode_changes=%0d required >=5", changes);
    end
    bus.en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      logic [11:0] ec;
      cyc();
      ec = (k == 3) ? 12'h301 : 12'h300;
      checks++;
      if (bus.count_bcd !== ec) begin
        failures++; $display("FAIL en_resume k=%0d count=%h required %h", k, bus.count_bcd, ec);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      bus.en    = ($urandom_range(0, 9) != 0);
      bus.up_dn = 1'($urandom_range(0, 1));
      bus.clear = ($urandom_range(0, 40) == 0);
      bus.load  = ($urandom_range(0, 25) == 0);
      case ($urandom_range(0, 3))
        0:       bus.load_val = 12'h999;
        1:       bus.load_val = 12'h000;
        default: bus.load_val = 12'($urandom);
      endcase
      cyc();
      checks++;
      if (bus.count_bcd !== int_to_bcd(m_val) || bus.wrap !== m_wrap ||
          bus.anode !== exp_anode() || bus.cathode !== exp_cathode()) begin
        failures++;
        $display("FAIL random k=%0d count=%h wrap=%b anode=%b cathode=%b required %h %b %b %b",
                 k, bus.count_bcd, bus.wrap, bus.anode, bus.cathode,
                 int_to_bcd(m_val), m_wrap, exp_anode(), exp_cathode());
      end
    end
    bus.clear = 1'b0; bus.load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_load_tick();
    test_scan();
    test_enable_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
